// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: decodes IR fields and sequences the shared memory port,
// PC, IR and register-file strobes. Define MCCTRL_TIMEOUT_EN to add the memory wait timeout.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                         ALU_SLTU = 4'b1001, ALU_LUI = 4'b1010, ALU_AUIPC = 4'b1011;

  state_t      st;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [31:0] instret_q;
  logic        illegal_q;
  logic        bus_err_q;
  logic        supported;
  logic        timeout;
  logic [3:0]  exec_op;
  logic [1:0]  exec_src;

`ifdef MCCTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  // The cycle that would make the count reach the limit traps, unless mem_ready arrives.
  assign timeout = mem_req && !mem_ready && (wait_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    supported = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: supported = 1'b1;
      default: ;
    endcase
  end

  // ALU control for EXEC, from the fields latched in DECODE
  always_comb begin
    exec_op  = ALU_ADD;
    exec_src = 2'b00;
    case (op_q)
      OP_R: begin
        case ({f7_q, f3_q})
          {7'b0000000, 3'b000}: exec_op = ALU_ADD;
          {7'b0100000, 3'b000}: exec_op = ALU_SUB;
          {7'b0000000, 3'b001}: exec_op = ALU_SLL;
          {7'b0000000, 3'b010}: exec_op = ALU_SLT;
          {7'b0000000, 3'b011}: exec_op = ALU_SLTU;
          {7'b0000000, 3'b100}: exec_op = ALU_XOR;
          {7'b0000000, 3'b101}: exec_op = ALU_SRL;
          {7'b0100000, 3'b101}: exec_op = ALU_SRA;
          {7'b0000000, 3'b110}: exec_op = ALU_OR;
          {7'b0000000, 3'b111}: exec_op = ALU_AND;
          default:              exec_op = ALU_ADD;
        endcase
      end
      OP_I: begin
        exec_src = 2'b01;
        case (f3_q)
          3'b000:  exec_op = ALU_ADD;
          3'b001:  exec_op = ALU_SLL;
          3'b010:  exec_op = ALU_SLT;
          3'b011:  exec_op = ALU_SLTU;
          3'b100:  exec_op = ALU_XOR;
          3'b101:  exec_op = (f7_q == 7'd0) ? ALU_SRL : ALU_SRA;
          3'b110:  exec_op = ALU_OR;
          default: exec_op = ALU_AND;
        endcase
      end
      OP_LD, OP_ST, OP_JALR: exec_src = 2'b01;
      OP_LUI:   begin exec_src = 2'b10; exec_op = ALU_LUI;   end
      OP_AUIPC: begin exec_src = 2'b10; exec_op = ALU_AUIPC; end
      OP_BR:    exec_op = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src    = 2'b00;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    if (rst_n) begin
      case (st)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        EXEC: begin
          alu_op  = exec_op;
          alu_src = exec_src;
          case (op_q)
            OP_BR:   begin pc_write = branch_taken; pc_src = 2'b01; end
            OP_JAL:  begin pc_write = 1'b1;         pc_src = 2'b01; end
            OP_JALR: begin pc_write = 1'b1;         pc_src = 2'b10; end
            default: ;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (op_q == OP_ST);
          alu_src = 2'b01;
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LD);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= FETCH;
      op_q      <= 7'd0;
      f3_q      <= 3'd0;
      f7_q      <= 7'd0;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MCCTRL_TIMEOUT_EN
      wait_cnt  <= 8'd0;
`endif
    end else begin
`ifdef MCCTRL_TIMEOUT_EN
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
`endif
      case (st)
        FETCH: begin
          if (mem_ready) st <= DECODE;
          else if (timeout) begin
            st        <= TRAP;
            bus_err_q <= 1'b1;
          end
        end
        DECODE: begin
          op_q <= opcode;
          f3_q <= funct3;
          f7_q <= funct7;
          if (supported) st <= EXEC;
          else begin
            st        <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          case (op_q)
            OP_BR: begin
              st        <= FETCH;
              instret_q <= instret_q + 32'd1;
            end
            OP_LD, OP_ST: st <= MEM;
            default:      st <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (op_q == OP_ST) begin
              st        <= FETCH;
              instret_q <= instret_q + 32'd1;
            end else st <= WB;
          end else if (timeout) begin
            st        <= TRAP;
            bus_err_q <= 1'b1;
          end
        end
        WB: begin
          st        <= FETCH;
          instret_q <= instret_q + 32'd1;
        end
        TRAP:    st <= TRAP;
        default: st <= TRAP;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state   = st;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM that sequences the RV32I integer datapath over several cycles instead of one, so instruction and data accesses share a single memory port.
- Decodes opcode/funct3/funct7 into the team ALU-op and ALU-source encodings, then issues per-state strobes for the PC, IR, memory port and register file.
- Sits between the IR fields and the datapath muxes/enables. Also counts retired instructions.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a memory request may wait for mem_ready; only used when the timeout feature is compiled in. Range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- mem_ready  in  1  memory accepted/completed the current request this cycle.
- branch_taken  in  1  datapath comparator result for the current branch, valid in EXEC.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write qualifier for mem_req.
- iord  out  1  0 = address from PC, 1 = address from ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  2  00 = pc+4, 01 = old_pc+imm (branch/jal), 10 = ALU result & ~1 (jalr).
- alu_src  out  2  00 = rs2, 01 = I/S immediate, 10 = U immediate.
- alu_op  out  4  team encoding: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001, lui 1010, auipc 1011.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU/link.
- illegal  out  1  sticky; an unsupported opcode was decoded.
- bus_err  out  1  sticky; memory timeout (feature only, else tied 0).
- instret  out  32  retired-instruction count.
- state  out  3  current state, for debug.

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Reset:
  - While rst_n = 0 at a clock edge: state <= FETCH, instret <= 0, illegal <= 0, bus_err <= 0, latched decode fields <= 0.
  - While rst_n is low, all strobe outputs are forced 0.
  - Reset has priority over any in-flight request; the request is abandoned and no write occurs.
- Outputs are decoded combinationally from state plus the latched fields (Moore-style). Default for every strobe is 0.
- FETCH:
  - mem_req = 1, iord = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 00, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Latch opcode/funct3/funct7.
  - Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> go to EXEC.
  - Any other opcode -> TRAP, with illegal <= 1 on that edge.
- EXEC (alu_op/alu_src per opcode):
  - R-type: alu_src = 00; alu_op from {funct7, funct3}; undefined combinations give add.
  - I-type ALU: alu_src = 01; funct3 101 with funct7 = 0 gives srl, otherwise sra.
  - Load/store: alu_src = 01, alu_op = add.
  - LUI: alu_src = 10, alu_op = 1010.
  - AUIPC: alu_src = 10, alu_op = 1011.
  - Branch: alu_op = sub. pc_write = branch_taken, pc_src = 01. Retire, then go to FETCH.
  - JAL: pc_write = 1, pc_src = 01. JALR: alu_src = 01, pc_write = 1, pc_src = 10. Both then go to WB for the link write.
  - Load/store -> MEM. All other supported opcodes -> WB.
- MEM:
  - mem_req = 1, iord = 1, mem_we = (store), alu_op stays add.
  - On mem_ready: load -> WB; store -> retire, then FETCH.
- WB:
  - reg_write = 1, mem_to_reg = (load). Retire, then FETCH.
  - JAL/JALR writes the link value pc+4, with mem_to_reg = 0.
- Retire: instret increments by 1 on the edge leaving the final state of an instruction; 32-bit wrap from 0xFFFFFFFF to 0.
- Cycle counts with zero-wait memory (mem_ready = 1 in the same cycle):
  - branch: 3
  - R/I/LUI/AUIPC/JAL/JALR: 4
  - store: 4
  - load: 5
  - Each wait cycle adds 1.
- TRAP: all strobes 0, no retire. Exit only via reset.
- mem_ready is ignored outside FETCH and MEM.

Optional Feature:
- Macro: MCCTRL_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on entry to FETCH/MEM and increments on each cycle mem_req = 1 and mem_ready = 0.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0, go to TRAP with bus_err <= 1. mem_ready on that same cycle wins.
- When undefined: no counter, FETCH/MEM wait indefinitely, bus_err = 0.

Test Plan:
- Reset, then `add` (0x00208033) with mem_ready = 1 -> states 0,1,2,4,0; alu_op = 0000, reg_write = 1 in WB only; instret = 1.
- `lw` (opcode 0000011) with mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles with mem_req = 1 and iord = 1; 7 cycles total; mem_to_reg = 1 in WB.
- `beq` with branch_taken = 1, then with 0 -> 3 cycles each; pc_write = 1 and pc_src = 01 in EXEC only when taken; reg_write never 1.
- Opcode 0x7F -> TRAP at cycle 3 with illegal = 1; stays in TRAP 10 further cycles; rst_n = 0 for one edge -> FETCH, illegal = 0, instret = 0.
- `srai` (funct3 101, funct7 0100000) -> alu_op = 0111 in EXEC; `srli` -> 0110.
- With MCCTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles with bus_err = 1, ir_write never asserted.
